rv_core_bus_host: RTL and testbench
===================================

// Module: rv_core_bus_host
// PURPOSE
// - Parametrised core-to-bus host adapter: converts a core req/gnt/rvalid memory port into
//   TL-UL style A/D channels (valid/ready).
// - Tracks up to MaxReqs outstanding transactions, tags each with a wrapping source ID and
//   checks in-order responses.
// - Adds an enable/drain mode that stops granting and reports idle once the bus is quiescent.
// - Sits between the Ibex core and the fabric FIFO, one instance per instr/data port.
// PARAMETERS
// - AddrWidth    32  address width
// - DataWidth    32  data width; byte-enable width BeW = DataWidth/8
// - MaxReqs      2   max outstanding A-channel requests (>=1); ICache ports use 8
// - SourceWidth  8   a_source/d_source width; must satisfy 2**SourceWidth >= MaxReqs
// - CheckSource  1   1: flag d_source mismatch as error; 0: ignore d_source
// PORTS
// - clk_i        in   1          clock
// - rst_ni       in   1          synchronous active-low reset
// - en_i         in   1          1: grant new requests; 0: drain and go idle
// - req_i        in   1          core request
// - gnt_o        out  1          request accepted this cycle
// - we_i         in   1          write
// - be_i         in   BeW        byte enables
// - addr_i       in   AddrWidth  address
// - wdata_i      in   DataWidth  write data
// - rvalid_o     out  1          response valid to core
// - rdata_o      out  DataWidth  read data
// - err_o        out  1          response error (qualified by rvalid_o)
// - a_valid_o    out  1          A channel valid
// - a_ready_i    in   1          A channel ready
// - a_opcode_o   out  3          0 PutFullData, 1 PutPartialData, 4 Get
// - a_addr_o     out  AddrWidth  {addr_i[AW-1:2],2'b00}
// - a_mask_o     out  BeW        be_i for writes, all ones for reads
// - a_data_o     out  DataWidth  wdata_i for writes, 0 for reads
// - a_source_o   out  SourceWidth tag of current request
// - d_valid_i    in   1          D channel valid
// - d_ready_o    out  1          tied to 1
// - d_data_i     in   DataWidth  response data
// - d_error_i    in   1          response error
// - d_source_i   in   SourceWidth response tag
// - idle_o       out  1          drain complete, no outstanding requests
// - spurious_o   out  1          sticky: response received with zero outstanding
// BEHAVIOUR
// - Reset (rst_ni=0 at posedge): state=RUN, outstanding=0, a_source tag=0,
//   expected tag=0, idle_o=0, spurious_o=0.
// - Combinational outputs follow inputs during reset; gnt_o=0 while outstanding=MaxReqs.
// - full = (outstanding==MaxReqs), counter width $clog2(MaxReqs+1).
// - a_valid_o = req_i & (state==RUN) & en_i & ~full; independent of a_ready_i.
// - gnt_o = a_valid_o & a_ready_i; zero-latency grant, request fields pass straight through.
// - Opcode rule: write with be_i all ones -> PutFullData; write otherwise -> PutPartialData;
//   read -> Get.
// - On gnt_o: a_source tag increments mod MaxReqs, wrapping MaxReqs-1 -> 0.
// - rvalid_o = d_valid_i & (outstanding!=0); rdata_o=d_data_i; same-cycle, no buffering.
// - err_o = d_error_i | (CheckSource & d_source_i != expected tag).
// - On a response with outstanding!=0: expected tag increments mod MaxReqs.
// - Response when outstanding==0: dropped (rvalid_o=0), spurious_o set until reset.
// - outstanding: +1 on grant, -1 on accepted response, unchanged when both occur in one cycle.
// - FSM:
//   - RUN  : en_i=0 -> DRAIN
//   - DRAIN: no grants; en_i=1 -> RUN; else outstanding==0 (after this cycle's update) -> IDLE
//   - IDLE : idle_o=1, no grants; en_i=1 -> RUN (idle_o=0 next cycle)
// - en_i deassert with a request pending: no grant from that cycle on, even if a_ready_i=1.
//   The core holds req_i.
// TESTING
// - Read: req_i=1, addr=0x1000_0007, we=0, a_ready=1 -> gnt_o same cycle, a_opcode=4,
//   a_addr=0x1000_0004, mask=0xF, source=0. Then d_valid, d_data=0xDEAD_BEEF ->
//   rvalid_o=1, rdata_o=0xDEAD_BEEF, err_o=0.
// - Writes: be=0xF -> opcode 0; be=0x3 -> opcode 1, a_mask=0x3, a_data=wdata.
// - Full, MaxReqs=2: two grants with no response -> third req gets gnt_o=0, a_valid_o=0.
//   One response -> grant resumes next cycle.
// - Simultaneous grant and response at outstanding=1: outstanding stays 1; source tag
//   wraps 1->0 after 2 grants.
// - Drain: 2 outstanding, en_i=0 -> no grants, idle_o=0 until 2nd response, idle_o=1
//   the cycle after. en_i=1 -> next cycle idle_o=0 and grants resume.
// - Errors: d_source=1 when expecting 0 -> err_o=1. Response at outstanding=0 ->
//   rvalid_o=0, spurious_o=1 sticky. Reset mid-operation -> all counters 0, spurious_o=0.

Source files
------------

// File: rtl/rv_core_bus_host.sv
// rv_core_bus_host: core req/gnt/rvalid port to TL-UL A/D channel adapter with
// outstanding-request tracking, wrapping source tags and an enable/drain mode.
module rv_core_bus_host #(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int MaxReqs     = 2,
    parameter int SourceWidth = 8,
    parameter bit CheckSource = 1'b1,
    localparam int BeW        = DataWidth / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic                   we_i,
    input  logic [BeW-1:0]         be_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    output logic                   a_valid_o,
    input  logic                   a_ready_i,
    output logic [2:0]             a_opcode_o,
    output logic [AddrWidth-1:0]   a_addr_o,
    output logic [BeW-1:0]         a_mask_o,
    output logic [DataWidth-1:0]   a_data_o,
    output logic [SourceWidth-1:0] a_source_o,
    input  logic                   d_valid_i,
    output logic                   d_ready_o,
    input  logic [DataWidth-1:0]   d_data_i,
    input  logic                   d_error_i,
    input  logic [SourceWidth-1:0] d_source_i,
    output logic                   idle_o,
    output logic                   spurious_o
);
    localparam int CntW = $clog2(MaxReqs + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxReqs);
    localparam logic [SourceWidth-1:0] LastTag = SourceWidth'(MaxReqs - 1);

    typedef enum logic [1:0] {Run, Drain, Idle} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        outst_q, outst_d;
    logic [SourceWidth-1:0] tag_q, tag_d, exp_q, exp_d;
    logic                   spurious_q, spurious_d;

    always_comb begin
        a_valid_o  = req_i & (state_q == Run) & en_i & (outst_q != MaxCnt);
        gnt_o      = a_valid_o & a_ready_i;
        a_opcode_o = we_i ? (&be_i ? 3'd0 : 3'd1) : 3'd4;
        a_addr_o   = {addr_i[AddrWidth-1:2], 2'b00};
        a_mask_o   = we_i ? be_i : '1;
        a_data_o   = we_i ? wdata_i : '0;
        a_source_o = tag_q;
        d_ready_o  = 1'b1;
        // responses with nothing outstanding are dropped and only flagged
        rvalid_o   = d_valid_i & (outst_q != '0);
        rdata_o    = d_data_i;
        err_o      = d_error_i | (CheckSource & (d_source_i != exp_q));
        tag_d      = gnt_o ? (tag_q == LastTag ? '0 : tag_q + SourceWidth'(1)) : tag_q;
        exp_d      = rvalid_o ? (exp_q == LastTag ? '0 : exp_q + SourceWidth'(1)) : exp_q;
        outst_d    = (gnt_o & ~rvalid_o) ? outst_q + CntW'(1) :
                     (~gnt_o & rvalid_o) ? outst_q - CntW'(1) : outst_q;
        spurious_d = spurious_q | (d_valid_i & (outst_q == '0));
        state_d    = state_q == Run ? (en_i ? Run : Drain) :
                     en_i ? Run :
                     (state_q == Drain && outst_d == '0) ? Idle : state_q;
        idle_o     = state_q == Idle;
        spurious_o = spurious_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= Run;
            outst_q    <= '0;
            tag_q      <= '0;
            exp_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            outst_q    <= outst_d;
            tag_q      <= tag_d;
            exp_q      <= exp_d;
            spurious_q <= spurious_d;
        end
    end
endmodule

// File: tb/tb_rv_core_bus_host.sv
// tb_rv_core_bus_host: directed vectors with queued A/D expectations checked by
// independent channel monitors.
module tb_rv_core_bus_host;
    localparam int MR = 2;

    logic        clk_i = 1'b0, rst_ni = 1'b0, en_i = 1'b1, req_i = 1'b0, we_i = 1'b0;
    logic        a_ready_i = 1'b1, d_valid_i = 1'b0, d_error_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0, d_data_i = '0;
    logic [7:0]  d_source_i = '0;
    logic        gnt_o, rvalid_o, err_o, a_valid_o, d_ready_o, idle_o, spurious_o;
    logic [31:0] rdata_o, a_addr_o, a_data_o;
    logic [2:0]  a_opcode_o;
    logic [3:0]  a_mask_o;
    logic [7:0]  a_source_o;

    rv_core_bus_host dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .req_i(req_i), .gnt_o(gnt_o),
        .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_opcode_o(a_opcode_o),
        .a_addr_o(a_addr_o), .a_mask_o(a_mask_o), .a_data_o(a_data_o),
        .a_source_o(a_source_o), .d_valid_i(d_valid_i), .d_ready_o(d_ready_o),
        .d_data_i(d_data_i), .d_error_i(d_error_i), .d_source_i(d_source_i),
        .idle_o(idle_o), .spurious_o(spurious_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [7:0]  src;
    } a_t;
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } d_t;

    a_t   a_q[$];
    d_t   d_q[$];
    int   vectors = 0, miscompares = 0;
    logic [7:0] stag = 8'h0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && gnt_o) begin
            a_t e;
            if (a_q.size() == 0) chk("a_unexpected_grant", {31'h0, gnt_o}, 32'h0);
            else begin
                e = a_q.pop_front();
                chk("a_opcode", {29'h0, a_opcode_o}, {29'h0, e.op});
                chk("a_addr", a_addr_o, e.addr);
                chk("a_mask", {28'h0, a_mask_o}, {28'h0, e.mask});
                chk("a_data", a_data_o, e.data);
                chk("a_source", {24'h0, a_source_o}, {24'h0, e.src});
                chk("d_ready", {31'h0, d_ready_o}, 32'h1);
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni && rvalid_o) begin
            d_t e;
            if (d_q.size() == 0) chk("d_unexpected_rvalid", {31'h0, rvalid_o}, 32'h0);
            else begin
                e = d_q.pop_front();
                chk("rdata", rdata_o, e.data);
                chk("err", {31'h0, err_o}, {31'h0, e.err});
            end
        end
    end

    task automatic step(input bit rst, e, r, w, input logic [3:0] be,
                        input logic [31:0] ad, wd, input bit ar, av, g, dv,
                        input logic [31:0] dd, input bit de, input logic [7:0] ds,
                        input bit rv, er, idl, sp);
        rst_ni = ~rst; en_i = e; req_i = r; we_i = w; be_i = be; addr_i = ad;
        wdata_i = wd; a_ready_i = ar; d_valid_i = dv; d_data_i = dd;
        d_error_i = de; d_source_i = ds;
        if (g) begin
            a_q.push_back('{w ? (be == 4'hF ? 3'd0 : 3'd1) : 3'd4, {ad[31:2], 2'b00},
                           w ? be : 4'hF, w ? wd : 32'h0, stag});
            stag = (stag == 8'(MR - 1)) ? 8'h0 : stag + 8'h1;
        end
        if (rv) d_q.push_back('{dd, er});
        if (rst) stag = 8'h0;
        @(negedge clk_i);
        if (!rst) begin
            chk("a_valid", {31'h0, a_valid_o}, {31'h0, av});
            chk("gnt", {31'h0, gnt_o}, {31'h0, g});
            chk("rvalid", {31'h0, rvalid_o}, {31'h0, rv});
            chk("idle", {31'h0, idle_o}, {31'h0, idl});
            chk("spurious", {31'h0, spurious_o}, {31'h0, sp});
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // rst e r w be addr wdata ar av g dv ddata de ds rv er idle sp
        step(1, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        // read then response
        step(0, 1, 1, 0, 4'h0, 32'h1000_0007, 32'h0, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, 32'hDEAD_BEEF, 0, 8'd0, 1, 0, 0, 0);
        // full and partial writes
        step(0, 1, 1, 1, 4'hF, 32'h2000_0000, 32'h1234_5678, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, 32'h0, 0, 8'd1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 4'h3, 32'h2000_0012, 32'hCAFE_F00D, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, 32'h0, 0, 8'd0, 1, 0, 0, 0);
        // a_valid without a_ready
        step(0, 1, 1, 0, 4'h0, 32'h400, 32'h0, 0, 1, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        // fill to MaxReqs, blocked, then resume with simultaneous grant/response
        step(0, 1, 1, 0, 4'h0, 32'h100, 32'h0, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 32'h104, 32'h0, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 32'h108, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 32'h108, 32'h0, 1, 0, 0, 1, 32'h11, 0, 8'd1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 32'h108, 32'h0, 1, 1, 1, 1, 32'h22, 0, 8'd0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 32'h10C, 32'h0, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 32'h110, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        // drain with two outstanding
        step(0, 0, 1, 0, 4'h0, 32'h110, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 4'h0, 32'h110, 32'h0, 1, 0, 0, 1, 32'h33, 0, 8'd1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, 32'h44, 0, 8'd0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 4'h0, 32'h200, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 4'h0, 32'h200, 32'h0, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, 32'h55, 0, 8'd1, 1, 0, 0, 0);
        // source mismatch and bus error
        step(0, 1, 1, 0, 4'h0, 32'h300, 32'h0, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, 32'h66, 0, 8'd1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 4'h0, 32'h304, 32'h0, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, 32'h77, 1, 8'd1, 1, 1, 0, 0);
        // spurious response, sticky
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, 32'h88, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 4'h0, 32'h308, 32'h0, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 1);
        // reset mid-operation clears counters, tags and spurious flag
        step(1, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 32'h500, 32'h0, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 32'h504, 32'h0, 1, 1, 1, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 32'h508, 32'h0, 1, 0, 0, 0, 32'h0, 0, 8'd0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, 32'hA0, 0, 8'd0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 1, 32'hA1, 0, 8'd1, 1, 0, 0, 0);
        chk("a_queue_drained", a_q.size(), 32'h0);
        chk("d_queue_drained", d_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
